// File: rtl/bw_io_ddr_vref_code_ctl.sv
// DDR pad Vref select code controller.
// Slews the live 7-bit Vref code one LSB per STEP_DIV cycles toward a loaded
// target. After the final step it waits SETTLE_CYC cycles, then pulses done.
module bw_io_ddr_vref_code_ctl #(
  parameter int unsigned STEP_DIV   = 16,
  parameter int unsigned SETTLE_CYC = 64,
  parameter logic [6:0]  RESET_CODE = 7'h40
) (
  input  logic       clk,
  input  logic       rst_l,
  input  logic       ld_en,
  input  logic [6:0] ld_code,
  input  logic       hold,
  output logic [7:1] code,
  output logic       busy,
  output logic       done
);

  localparam int unsigned DIV_W = $clog2(STEP_DIV);
  localparam int unsigned SET_W = $clog2(SETTLE_CYC + 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(STEP_DIV - 1);
  localparam logic [SET_W-1:0] SET_LAST = SET_W'(SETTLE_CYC - 1);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_RAMP   = 2'd1;
  localparam logic [1:0] ST_SETTLE = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [6:0]       code_q, code_d;
  logic [6:0]       tgt_q, tgt_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [SET_W-1:0] set_q, set_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  assign code = code_q;
  assign busy = busy_q;
  assign done = done_q;

  // Next-state, step and settle counting.
  always_comb begin
    state_d = state_q;
    code_d  = code_q;
    tgt_d   = tgt_q;
    div_d   = div_q;
    set_d   = set_q;
    done_d  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (ld_en) begin
          if (ld_code == code_q) begin
            done_d = 1'b1;
          end else begin
            tgt_d   = ld_code;
            div_d   = '0;
            state_d = ST_RAMP;
          end
        end
      end

      ST_RAMP: begin
        // A step on the same edge as a load still heads toward the old target;
        // the arrival check then uses whichever target will be current next.
        if (!hold) begin
          if (div_q == DIV_LAST) begin
            div_d = '0;
            if (tgt_q > code_q) begin
              code_d = code_q + 7'd1;
            end else if (tgt_q < code_q) begin
              code_d = code_q - 7'd1;
            end
          end else begin
            div_d = div_q + 1'b1;
          end
        end
        if (ld_en) begin
          tgt_d = ld_code;
        end
        if (code_d == tgt_d) begin
          state_d = ST_SETTLE;
          set_d   = '0;
        end
      end

      ST_SETTLE: begin
        if (ld_en) begin
          tgt_d = ld_code;
          set_d = '0;
          if (ld_code != code_q) begin
            div_d   = '0;
            state_d = ST_RAMP;
          end
        end else if (!hold) begin
          if (set_q == SET_LAST) begin
            set_d   = '0;
            done_d  = 1'b1;
            state_d = ST_IDLE;
          end else begin
            set_d = set_q + 1'b1;
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  // State and output registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      state_q <= ST_IDLE;
      code_q  <= RESET_CODE;
      tgt_q   <= RESET_CODE;
      div_q   <= '0;
      set_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      code_q  <= code_d;
      tgt_q   <= tgt_d;
      div_q   <= div_d;
      set_q   <= set_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

endmodule

// File: tb/tb_bw_io_ddr_vref_code_ctl.sv
// Directed bench for bw_io_ddr_vref_code_ctl with STEP_DIV=4, SETTLE_CYC=8.
// Cycle T+k is sampled on the falling edge after rising edge T+k-1, where
// rising edge T is the one that captures ld_en.
module tb_bw_io_ddr_vref_code_ctl;

  logic       clk;
  logic       rst_l;
  logic       ld_en;
  logic [6:0] ld_code;
  logic       hold;
  logic [7:1] code;
  logic       busy;
  logic       done;

  int tests;
  int fails;

  bw_io_ddr_vref_code_ctl #(
    .STEP_DIV  (4),
    .SETTLE_CYC(8),
    .RESET_CODE(7'h40)
  ) dut (
    .clk    (clk),
    .rst_l  (rst_l),
    .ld_en  (ld_en),
    .ld_code(ld_code),
    .hold   (hold),
    .code   (code),
    .busy   (busy),
    .done   (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [6:0] ld;
    int         done_at;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_l   = 1'b0;
    ld_en   = 1'b0;
    hold    = 1'b0;
    ld_code = 7'h00;
    #1;
    chk("rst_code", int'(code), 'h40);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    @(negedge clk);
    rst_l = 1'b1;
    @(negedge clk);
  endtask

  // Drives ld_en for one rising edge (edge T); returns at the falling edge of cycle T+1.
  task automatic load(input logic [6:0] c);
    ld_code = c;
    ld_en   = 1'b1;
    @(negedge clk);
    ld_en = 1'b0;
  endtask

  initial begin
    tests = 0;
    fails = 0;
    rst_l = 1'b1;
    ld_en = 1'b0;
    hold  = 1'b0;
    ld_code = 7'h00;

    vecs[0] = '{7'h43, 21};
    vecs[1] = '{7'h3E, 17};
    vecs[2] = '{7'h40, 1};
    vecs[3] = '{7'h41, 13};
    vecs[4] = '{7'h3F, 13};
    vecs[5] = '{7'h45, 29};

    // Table-driven ramps from reset: every cycle up to two past done.
    for (int v = 0; v < 6; v++) begin
      int n;
      int dir;
      do_reset();
      n   = (int'(vecs[v].ld) >= 'h40) ? int'(vecs[v].ld) - 'h40 : 'h40 - int'(vecs[v].ld);
      dir = (int'(vecs[v].ld) >= 'h40) ? 1 : -1;
      load(vecs[v].ld);
      for (int k = 1; k <= vecs[v].done_at + 2; k++) begin
        int m;
        if (k > 1) @(negedge clk);
        m = (k - 1) / 4;
        if (m > n) m = n;
        chk($sformatf("v%0d_code_k%0d", v, k), int'(code), 'h40 + dir * m);
        chk($sformatf("v%0d_busy_k%0d", v, k), int'(busy),
            (n > 0 && k < vecs[v].done_at) ? 1 : 0);
        chk($sformatf("v%0d_done_k%0d", v, k), int'(done), (k == vecs[v].done_at) ? 1 : 0);
      end
    end

    // Hold for cycles T+3..T+12 during the 0x43 ramp.
    do_reset();
    load(7'h43);
    for (int k = 1; k <= 32; k++) begin
      if (k > 1) @(negedge clk);
      if (k == 3) hold = 1'b1;
      if (k == 13) hold = 1'b0;
      if (k == 14) chk("hold_code_k14", int'(code), 'h40);
      if (k == 15) chk("hold_code_k15", int'(code), 'h41);
      if (k == 19) chk("hold_code_k19", int'(code), 'h42);
      if (k == 22) chk("hold_code_k22", int'(code), 'h42);
      if (k == 23) chk("hold_code_k23", int'(code), 'h43);
      if (k == 30) chk("hold_done_k30", int'(done), 0);
      if (k == 30) chk("hold_busy_k30", int'(busy), 1);
      if (k == 31) chk("hold_done_k31", int'(done), 1);
      if (k == 31) chk("hold_busy_k31", int'(busy), 0);
      if (k == 32) chk("hold_done_k32", int'(done), 0);
    end

    // Retarget to 0x41 during SETTLE (ld_en at edge T+16).
    do_reset();
    load(7'h43);
    for (int k = 1; k <= 34; k++) begin
      if (k > 1) @(negedge clk);
      if (k == 16) begin
        ld_code = 7'h41;
        ld_en   = 1'b1;
      end
      if (k == 17) ld_en = 1'b0;
      if (k >= 17 && k <= 32) chk($sformatf("rts_done_k%0d", k), int'(done), 0);
      if (k == 20) chk("rts_code_k20", int'(code), 'h43);
      if (k == 21) chk("rts_code_k21", int'(code), 'h42);
      if (k == 21) chk("rts_busy_k21", int'(busy), 1);
      if (k == 25) chk("rts_code_k25", int'(code), 'h41);
      if (k == 33) chk("rts_done_k33", int'(done), 1);
      if (k == 33) chk("rts_busy_k33", int'(busy), 0);
      if (k == 34) chk("rts_code_k34", int'(code), 'h41);
    end

    // Load on the same edge as settle completion (edge T+20): load wins.
    do_reset();
    load(7'h43);
    for (int k = 1; k <= 34; k++) begin
      if (k > 1) @(negedge clk);
      if (k == 20) begin
        ld_code = 7'h44;
        ld_en   = 1'b1;
      end
      if (k == 21) ld_en = 1'b0;
      if (k == 21) chk("sim_done_k21", int'(done), 0);
      if (k == 21) chk("sim_busy_k21", int'(busy), 1);
      if (k == 24) chk("sim_code_k24", int'(code), 'h43);
      if (k == 25) chk("sim_code_k25", int'(code), 'h44);
      if (k == 32) chk("sim_done_k32", int'(done), 0);
      if (k == 33) chk("sim_done_k33", int'(done), 1);
      if (k == 34) chk("sim_done_k34", int'(done), 0);
    end

    // Retarget in RAMP to the current code (ld_en at edge T+6, code is 0x41).
    do_reset();
    load(7'h43);
    for (int k = 1; k <= 16; k++) begin
      if (k > 1) @(negedge clk);
      if (k == 6) begin
        ld_code = 7'h41;
        ld_en   = 1'b1;
      end
      if (k == 7) ld_en = 1'b0;
      if (k == 10) chk("rtr_code_k10", int'(code), 'h41);
      if (k == 14) chk("rtr_done_k14", int'(done), 0);
      if (k == 15) chk("rtr_done_k15", int'(done), 1);
      if (k == 15) chk("rtr_code_k15", int'(code), 'h41);
      if (k == 16) chk("rtr_busy_k16", int'(busy), 0);
    end

    // Asynchronous reset mid-ramp, then a fresh load of 0x41.
    do_reset();
    load(7'h43);
    for (int k = 2; k <= 10; k++) @(negedge clk);
    chk("amr_code_pre", int'(code), 'h42);
    #1 rst_l = 1'b0;
    #1;
    chk("amr_code", int'(code), 'h40);
    chk("amr_busy", int'(busy), 0);
    chk("amr_done", int'(done), 0);
    @(negedge clk);
    rst_l = 1'b1;
    @(negedge clk);
    load(7'h41);
    chk("amr_busy_k1", int'(busy), 1);
    for (int k = 2; k <= 5; k++) begin
      @(negedge clk);
      if (k == 4) chk("amr_code_k4", int'(code), 'h40);
      if (k == 5) chk("amr_code_k5", int'(code), 'h41);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
